npc_lsu: RTL and testbench
==========================

// Module: npc_lsu
// PURPOSE
//  Parametrised load/store unit for the NPC core; replaces the fixed lw/lbu/sb/sw DPI memory path.
//  Takes one request from EXU (valid/ready), drives a variable-latency memory bus, and returns one response.
//  The response carries extracted and extended load data, the rd tag, and an error code, for WBU.
//  Supports byte/half/word (and dword when XLEN=64), signed/unsigned loads, misalign and bus-timeout errors.
// PARAMETERS
//  XLEN     32   data width; 32 or 64; STRB_W = XLEN/8, OFF_W = log2(STRB_W)
//  ADDR_W   32   address width
//  TIMEOUT  255  max cycles in WAIT before bus error; 0 disables timeout
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-high
//  req_valid    in   1       request valid
//  req_ready    out  1       request ready
//  req_we       in   1       1=store, 0=load
//  req_size     in   2       0=B 1=H 2=W 3=D
//  req_unsigned in   1       zero-extend load (lbu/lhu/lwu)
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   XLEN    store data, LSB-aligned
//  req_rd       in   5       dest tag, passed through
//  rsp_valid    out  1       response valid
//  rsp_ready    in   1       response accepted
//  rsp_rdata    out  XLEN    extended load data; 0 for stores/errors
//  rsp_rd       out  5       tag of this response
//  rsp_err      out  2       0=OK 1=MISALIGN 2=BUSERR 3=ILLEGAL_SIZE
//  mem_valid    out  1       bus request valid
//  mem_ready    in   1       bus request accepted
//  mem_we       out  1       bus write
//  mem_addr     out  ADDR_W  req_addr with low OFF_W bits cleared
//  mem_wdata    out  XLEN    lane-replicated store data
//  mem_wstrb    out  STRB_W  byte strobes; 0 for loads
//  mem_rvalid   in   1       read data / write ack valid
//  mem_rdata    in   XLEN    full-width read data
//  mem_err      in   1       bus error, qualified by mem_rvalid
// BEHAVIOUR
//  FSM states: IDLE, REQ, WAIT, RESP. Reset: IDLE; every output 0 except req_ready=1; timeout counter 0.
//  req_ready = (state==IDLE). On accept: latch all req_* fields; off = addr[OFF_W-1:0].
//  IDLE->RESP on accept if size illegal (3 with XLEN=32) -> err=3; else misaligned -> err=1 (no bus access).
//  Misaligned: H when off[0]!=0; W when off[1:0]!=0; D when off[2:0]!=0. Illegal size is checked first.
//  IDLE->REQ otherwise. In REQ: mem_valid=1; mem_* held stable until mem_ready; then go to WAIT.
//  WAIT: count cycles. On mem_rvalid -> RESP: err=2 if mem_err, else err=0.
//  WAIT timeout: no rvalid after TIMEOUT cycles -> RESP err=2. If rvalid and timeout coincide, rvalid wins.
//  mem_rvalid outside WAIT is ignored. The bus must not return rvalid in the mem_ready cycle.
//  Stores complete on mem_rvalid (write ack); mem_rdata is ignored for stores.
//  Store strobes: B=1<<off, H=3<<off, W=4'hF<<off, D=all ones.
//  Store data: the low byte/half/word of req_wdata replicated across every lane.
//  Load data: shift mem_rdata right by off*8, keep size bits, sign-extend unless unsigned or D.
//  RESP: rsp_valid=1 and all rsp_* stable until rsp_ready; then go to IDLE (no back-to-back accept).
//  Latency with zero bus wait: accept T, mem_valid T+1, rvalid T+2, rsp_valid T+3. Error responses: rsp_valid T+1.
//  Reset at any state aborts the operation: mem_valid and rsp_valid drop asynchronously and the pending result is lost.
//  One outstanding access only; the rd tag is never reordered.
// TESTING
//  1 XLEN=32 lbu 0x80000003, rdata 0x12345678 -> mem_addr 0x80000000, rsp_rdata 0x00000012, err 0, rsp at T+3
//  2 lb 0x80000001, rdata 0x00008000 -> 0xFFFFFF80; lhu 0x80000002, rdata 0x8001_0000 -> 0x00008001
//  3 sb wdata 0xAB at 0x80000002 -> mem_wstrb 4'b0100, mem_wdata 0xABABABAB, mem_we 1, rsp_rdata 0
//  4 lw 0x80000002 -> no mem_valid, rsp_valid at T+1 with err=1; size=3 at XLEN=32 -> err=3
//  5 mem_ready low 5 cycles -> mem_addr/wdata/wstrb stable; TIMEOUT=16 with no rvalid -> err=2 at WAIT cycle 16
//  6 rsp_ready low 3 cycles -> rsp_* stable and req_ready 0; rst in WAIT -> mem_valid 0 immediately, req_ready 1

Source files
------------

// File: rtl/npc_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : npc_lsu
//  Purpose  : Load/store unit for the NPC core. Accepts one request at a time,
//             drives a variable-latency memory bus and returns one response.
//  Revision : 1.0  initial release
// ============================================================================
module npc_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [4:0]          rsp_rd,
    output logic [1:0]          rsp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_err
);

    localparam int c_strb_w = XLEN / 8;
    localparam int c_off_w  = $clog2(c_strb_w);
    localparam int c_cnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam logic [1:0] c_sz_b = 2'd0;
    localparam logic [1:0] c_sz_h = 2'd1;
    localparam logic [1:0] c_sz_w = 2'd2;
    localparam logic [1:0] c_sz_d = 2'd3;

    localparam logic [1:0] c_err_ok       = 2'd0;
    localparam logic [1:0] c_err_misalign = 2'd1;
    localparam logic [1:0] c_err_bus      = 2'd2;
    localparam logic [1:0] c_err_illegal  = 2'd3;

    localparam logic [XLEN-1:0] c_mask_b = XLEN'(8'hFF);
    localparam logic [XLEN-1:0] c_mask_h = XLEN'(16'hFFFF);
    localparam logic [XLEN-1:0] c_mask_w = XLEN'(32'hFFFF_FFFF);
    localparam logic [XLEN-1:0] c_mask_d = '1;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [4:0]          r_rd;
    logic [1:0]          r_err;
    logic [XLEN-1:0]     r_rdata;
    logic [c_cnt_w-1:0]  r_cnt;

    logic [c_off_w-1:0]  w_req_off;
    logic [c_off_w-1:0]  w_off;
    logic                w_illegal;
    logic                w_misalign;
    logic                w_timeout;
    logic [XLEN-1:0]     w_shifted;
    logic [XLEN-1:0]     w_mask;
    logic                w_sign;
    logic [XLEN-1:0]     w_load;
    logic [c_strb_w-1:0] w_strb;

    // Request checks are evaluated on the live inputs so errors skip the bus.
    assign w_req_off = req_addr[c_off_w-1:0];
    assign w_illegal = (req_size == c_sz_d) && (XLEN != 64);

    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            c_sz_h:  w_misalign = w_req_off[0];
            c_sz_w:  w_misalign = |w_req_off[1:0];
            c_sz_d:  w_misalign = |w_req_off;
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_off     = r_addr[c_off_w-1:0];
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (req_valid) w_state_nxt = (w_illegal || w_misalign) ? c_st_resp : c_st_req;
            c_st_req:  if (mem_ready) w_state_nxt = c_st_wait;
            c_st_wait: if (mem_rvalid || w_timeout) w_state_nxt = c_st_resp;
            c_st_resp: if (rsp_ready) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        mem_valid = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            c_st_idle: req_ready = 1'b1;
            c_st_req:  mem_valid = 1'b1;
            c_st_resp: rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= 5'd0;
            r_err      <= c_err_ok;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else if (r_state == c_st_idle) begin
            if (req_valid) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_rd       <= req_rd;
                r_rdata    <= '0;
                r_cnt      <= '0;
                if (w_illegal) begin
                    r_err <= c_err_illegal;
                end else if (w_misalign) begin
                    r_err <= c_err_misalign;
                end else begin
                    r_err <= c_err_ok;
                end
            end
        end else if (r_state == c_st_wait) begin
            // A response arriving on the last counted cycle beats the timeout.
            if (mem_rvalid) begin
                r_err   <= mem_err ? c_err_bus : c_err_ok;
                r_rdata <= (r_we || mem_err) ? '0 : w_load;
            end else if (w_timeout) begin
                r_err   <= c_err_bus;
                r_rdata <= '0;
            end else if (TIMEOUT != 0) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_shifted = mem_rdata >> {w_off, 3'b000};
        w_mask    = c_mask_d;
        w_sign    = 1'b0;
        case (r_size)
            c_sz_b: begin w_mask = c_mask_b; w_sign = w_shifted[7];  end
            c_sz_h: begin w_mask = c_mask_h; w_sign = w_shifted[15]; end
            c_sz_w: begin w_mask = c_mask_w; w_sign = w_shifted[31]; end
            default: ;
        endcase
        w_load = (w_shifted & w_mask) | ((w_sign && !r_unsigned) ? ~w_mask : '0);
    end

    always_comb begin
        case (r_size)
            c_sz_b: begin
                w_strb    = c_strb_w'(1) << w_off;
                mem_wdata = {c_strb_w{r_wdata[7:0]}};
            end
            c_sz_h: begin
                w_strb    = c_strb_w'(3) << w_off;
                mem_wdata = {(XLEN/16){r_wdata[15:0]}};
            end
            c_sz_w: begin
                w_strb    = c_strb_w'(4'hF) << w_off;
                mem_wdata = {(XLEN/32){r_wdata[31:0]}};
            end
            default: begin
                w_strb    = '1;
                mem_wdata = r_wdata;
            end
        endcase
    end

    assign mem_we    = r_we;
    assign mem_wstrb = r_we ? w_strb : '0;
    assign mem_addr  = {r_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
    assign rsp_rdata = r_rdata;
    assign rsp_rd    = r_rd;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_npc_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npc_lsu
//  Purpose  : Scoreboard bench for npc_lsu (XLEN=32, TIMEOUT=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_npc_lsu;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic [4:0]        req_rd = 5'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [XLEN-1:0]   rsp_rdata;
    logic [4:0]        rsp_rd;
    logic [1:0]        rsp_err;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_rvalid = 1'b0;
    logic [XLEN-1:0]   mem_rdata = '0;
    logic              mem_err = 1'b0;

    npc_lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         acc_cyc = 0;
    logic [4:0] tag = 5'd1;
    bit         mon_seen = 1'b0;

    task automatic check(input string tag_s, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag_s, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err, input int exp_lat);
        exp_t e;
        int   k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_rd = tag;
        e.rd = tag; e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
        q.push_back(e);
        @(posedge clk); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        tag       = tag + 5'd1;
    endtask

    task automatic bus_serve(input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                             input logic [31:0] e_wdata, input int d_r, input int d_v,
                             input logic [31:0] rdata, input logic err, input logic junk, input logic no_rv);
        int k = 0;
        while (!mem_valid && k < 20) begin @(posedge clk); #1; k++; end
        check("mem_valid", 64'(mem_valid), 64'(1));
        if (!mem_valid) return;
        for (int i = 0; i <= d_r; i++) begin
            check("mem_valid_hold", 64'(mem_valid), 64'(1));
            check("mem_addr", 64'(mem_addr), 64'(e_addr));
            check("mem_we", 64'(mem_we), 64'(e_we));
            check("mem_wstrb", 64'(mem_wstrb), 64'(e_strb));
            check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
            if (i == d_r) begin
                mem_rvalid = 1'b0; mem_err = 1'b0; mem_ready = 1'b1;
            end else if (junk) begin
                mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h5A5A_5A5A;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0; mem_rdata = '0;
        check("mem_valid_drop", 64'(mem_valid), 64'(0));
        if (no_rv) return;
        for (int i = 0; i < d_v; i++) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    endtask

    task automatic wait_rsp();
        int k = 0;
        while (q.size() != 0 && k < 60) begin @(posedge clk); #1; k++; end
        check("rsp_done", 64'(q.size()), 64'(0));
    endtask

    task automatic load_op(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_rdata);
        issue(1'b0, size, uns, addr, 32'h0, exp_rdata, 2'd0, 3);
        bus_serve({addr[31:2], 2'b00}, 1'b0, 4'h0, 32'h0, 0, 0, rdata, 1'b0, 1'b0, 1'b0);
        wait_rsp();
    endtask

    task automatic store_op(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] e_strb, input logic [31:0] e_wdata, input int d_r);
        issue(1'b1, size, 1'b0, addr, wdata, 32'h0, 2'd0, 3 + d_r);
        bus_serve({addr[31:2], 2'b00}, 1'b1, e_strb, e_wdata, d_r, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        wait_rsp();
    endtask

    task automatic err_op(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [1:0] err);
        issue(we, size, 1'b0, addr, 32'h1234_5678, 32'h0, err, 1);
        check("no_mem_valid", 64'(mem_valid), 64'(0));
        wait_rsp();
    endtask

    // Response monitor: fields compared every cycle rsp_valid is up, popped on handshake.
    initial begin : p_mon
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                check("rsp_expected", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    if (!mon_seen) begin
                        mon_seen = 1'b1;
                        check("rsp_latency", 64'(cyc - acc_cyc + 1), 64'(q[0].lat));
                    end
                    check("rsp_rd", 64'(rsp_rd), 64'(q[0].rd));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(q[0].rdata));
                    check("rsp_err", 64'(rsp_err), 64'(q[0].err));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        mon_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_rd", 64'(rsp_rd), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Loads: extraction and extension
        load_op(2'd0, 1'b1, 32'h8000_0003, 32'h1234_5678, 32'h0000_0012);
        load_op(2'd0, 1'b0, 32'h8000_0001, 32'h0000_8000, 32'hFFFF_FF80);
        load_op(2'd1, 1'b1, 32'h8000_0002, 32'h8001_0000, 32'h0000_8001);
        load_op(2'd1, 1'b0, 32'h8000_0002, 32'h8001_0000, 32'hFFFF_8001);
        load_op(2'd0, 1'b0, 32'h8000_0000, 32'h1234_56F0, 32'hFFFF_FFF0);
        load_op(2'd0, 1'b0, 32'h8000_0002, 32'h127F_5678, 32'h0000_007F);
        load_op(2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Stores: strobes and lane replication; last one stalls mem_ready 5 cycles
        store_op(2'd0, 32'h8000_0002, 32'hFFFF_FFAB, 4'b0100, 32'hABAB_ABAB, 0);
        store_op(2'd1, 32'h8000_0006, 32'h1234_5678, 4'b1100, 32'h5678_5678, 0);
        store_op(2'd2, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 5);

        // Alignment and size errors never touch the bus
        err_op(1'b0, 2'd2, 32'h8000_0002, 2'd1);
        err_op(1'b1, 2'd1, 32'h8000_0003, 2'd1);
        err_op(1'b1, 2'd2, 32'h8000_0001, 2'd1);
        err_op(1'b0, 2'd1, 32'h8000_0001, 2'd1);
        err_op(1'b0, 2'd3, 32'h8000_0000, 2'd3);
        err_op(1'b0, 2'd3, 32'h8000_0001, 2'd3);

        // Bus error on load and store
        issue(1'b0, 2'd2, 1'b0, 32'h8000_000C, 32'h0, 32'h0, 2'd2, 5);
        bus_serve(32'h8000_000C, 1'b0, 4'h0, 32'h0, 0, 2, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        wait_rsp();
        issue(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_0033, 32'h0, 2'd2, 3);
        bus_serve(32'h8000_0000, 1'b1, 4'b0010, 32'h3333_3333, 0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        wait_rsp();

        // Timeout: 16 silent WAIT cycles, then rvalid on the last counted cycle wins
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 2'd2, 3 + TIMEOUT - 1);
        bus_serve(32'h8000_0010, 1'b0, 4'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        wait_rsp();
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0014, 32'h0, 32'h7654_3210, 2'd0, 3 + TIMEOUT - 1);
        bus_serve(32'h8000_0014, 1'b0, 4'h0, 32'h0, 0, TIMEOUT - 1, 32'h7654_3210, 1'b0, 1'b0, 1'b0);
        wait_rsp();

        // Response backpressure
        rsp_ready = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0018, 32'h0, 32'h0BAD_F00D, 2'd0, 3);
        bus_serve(32'h8000_0018, 1'b0, 4'h0, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_req_ready", 64'(req_ready), 64'(0));
            check("stall_rsp_valid", 64'(rsp_valid), 64'(1));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_rsp();

        // Reset while in REQ: mem_valid drops before any clock edge
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 32'h0, 2'd0, 3);
        check("abort_req_mem_valid", 64'(mem_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("abort_req_mem_valid_low", 64'(mem_valid), 64'(0));
        check("abort_req_req_ready", 64'(req_ready), 64'(1));
        check("abort_req_rsp_valid", 64'(rsp_valid), 64'(0));
        void'(q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset while in WAIT: result is discarded
        issue(1'b0, 2'd2, 1'b0, 32'h8000_0024, 32'h0, 32'h0, 2'd0, 3);
        bus_serve(32'h8000_0024, 1'b0, 4'h0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_wait_req_ready", 64'(req_ready), 64'(1));
        check("abort_wait_mem_valid", 64'(mem_valid), 64'(0));
        check("abort_wait_mem_addr", 64'(mem_addr), 64'(0));
        void'(q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_wait_no_rsp", 64'(rsp_valid), 64'(0));

        // Recovery after abort
        load_op(2'd1, 1'b1, 32'h8000_0030, 32'h0000_BEEF, 32'h0000_BEEF);

        check("queue_empty", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
